// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame capture block.
// State encoding, measurement width and address sizing.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } state_t;

  localparam int MEAS_W = 16;
  localparam logic [MEAS_W-1:0] MEAS_MAX = '1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MEAS_W-1:0] sat_inc(
    input logic [MEAS_W-1:0] v
  );
    return (v == MEAS_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port,
// one synchronous read port with 1-cycle latency.
module frame_ram #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_capture.sv
// Captures one fval/lval/dval frame into RAM, measures it,
// then replays it on a valid/ready stream with line markers.
module frame_capture
  import frame_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 640,
  parameter int MAX_H = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fval,
  input  logic              lval,
  input  logic              dval,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_w,
  output logic [15:0]       frame_h,
  output logic              err_len,
  output logic              err_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof
);

  localparam int CW = $clog2(MAX_W + 1);
  localparam int RW = $clog2(MAX_H + 1);
  localparam int AW = addr_w(MAX_W * MAX_H);
  localparam int BW = PIX_W + 3;
  localparam logic [CW-1:0] W_LIM = CW'(MAX_W);
  localparam logic [RW-1:0] H_LIM = RW'(MAX_H);

  state_t state, state_n;
  logic   done_n;

  logic fval_q, lval_q, line_act;
  logic fval_rise, fval_fall;
  logic in_cap, in_rd, enter;
  logic line_start, line_end, pix, wr_ok, we;

  logic [CW-1:0]     col, col_cur;
  logic [RW-1:0]     row;
  logic [MEAS_W-1:0] col_m, col_m_cur, row_m;

  logic [AW-1:0]    waddr, raddr;
  logic [PIX_W-1:0] rdata;

  logic [CW-1:0] sw, rx;
  logic [RW-1:0] sh, ry;
  logic          rd_fin, rd_v, skid_v, pop, issue;
  logic          i_sol, i_eol, i_eof;
  logic [2:0]    rd_mk;
  logic [1:0]    occ;
  logic [BW-1:0] skid, out_q;

  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;
  assign in_cap    = (state == CAPTURE);
  assign in_rd     = (state == READOUT);
  assign enter     = (state == ARMED) & fval_rise;

  assign line_start = in_cap & fval & lval & ~lval_q;
  assign line_end   = in_cap & line_act & (~lval | ~fval);
  assign pix = in_cap & fval & lval & dval & (line_act | ~lval_q);

  assign col_cur   = line_start ? '0 : col;
  assign col_m_cur = line_start ? '0 : col_m;
  assign wr_ok     = (col_cur < W_LIM) & (row < H_LIM);
  assign we        = pix & wr_ok;
  assign waddr     = AW'(row) * AW'(MAX_W) + AW'(col_cur);

  frame_ram #(
    .PIX_W (PIX_W),
    .DEPTH (MAX_W * MAX_H),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (pix_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fval_q   <= 1'b0;
      lval_q   <= 1'b0;
      line_act <= 1'b0;
      col      <= '0;
      col_m    <= '0;
      row      <= '0;
      row_m    <= '0;
      frame_w  <= '0;
      frame_h  <= '0;
      err_len  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      fval_q <= fval;
      lval_q <= lval;
      if (enter) begin
        line_act <= 1'b0;
        col      <= '0;
        col_m    <= '0;
        row      <= '0;
        row_m    <= '0;
        frame_w  <= '0;
        frame_h  <= '0;
        err_len  <= 1'b0;
        err_ovf  <= 1'b0;
      end else begin
        if (line_start) begin
          line_act <= 1'b1;
          col      <= '0;
          col_m    <= '0;
        end
        if (pix) begin
          col   <= (col_cur == W_LIM) ? col_cur
                                      : col_cur + 1'b1;
          col_m <= sat_inc(col_m_cur);
          if (!wr_ok) err_ovf <= 1'b1;
        end
        if (line_end) begin
          if (row_m == '0) frame_w <= col_m;
          else if (col_m != frame_w) err_len <= 1'b1;
          row_m    <= sat_inc(row_m);
          frame_h  <= sat_inc(row_m);
          line_act <= 1'b0;
          if (row != H_LIM) row <= row + 1'b1;
        end
      end
    end
  end

  // Readout: read issue is credit-limited to two beats held
  // downstream of the RAM (output register + skid).
  assign sw = (frame_w > MEAS_W'(MAX_W)) ? W_LIM : CW'(frame_w);
  assign sh = (frame_h > MEAS_W'(MAX_H)) ? H_LIM : RW'(frame_h);

  assign pop   = out_valid & out_ready;
  assign occ   = {1'b0, out_valid} + {1'b0, skid_v} + {1'b0, rd_v};
  assign issue = in_rd & ~rd_fin & (sw != '0)
               & ((occ - {1'b0, pop}) < 2'd2);
  assign i_sol = (rx == '0);
  assign i_eol = (rx == sw - 1'b1);
  assign i_eof = i_eol & (ry == sh - 1'b1);
  assign raddr = AW'(ry) * AW'(MAX_W) + AW'(rx);

  always_ff @(posedge clk) begin
    if (rst || !in_rd) begin
      rx        <= '0;
      ry        <= '0;
      rd_fin    <= 1'b0;
      rd_v      <= 1'b0;
      rd_mk     <= '0;
      skid_v    <= 1'b0;
      skid      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        rd_mk <= {i_sol, i_eol, i_eof};
        if (i_eol) begin
          rx <= '0;
          ry <= ry + 1'b1;
        end else begin
          rx <= rx + 1'b1;
        end
        if (i_eof) rd_fin <= 1'b1;
      end
      if (!out_valid || out_ready) begin
        if (skid_v) begin
          out_q     <= skid;
          out_valid <= 1'b1;
          skid_v    <= rd_v;
          skid      <= {rdata, rd_mk};
        end else begin
          out_valid <= rd_v;
          if (rd_v) out_q <= {rdata, rd_mk};
        end
      end else if (rd_v) begin
        skid_v <= 1'b1;
        skid   <= {rdata, rd_mk};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (arm) state_n = ARMED;
      ARMED: if (fval_rise) state_n = CAPTURE;
      CAPTURE: begin
        if (fval_fall) begin
          if (row_m != '0 || line_end) begin
            state_n = READOUT;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      READOUT: begin
        if (sw == '0 || (pop && out_q[0])) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign out_data = out_q[BW-1:3];
  assign out_sol  = out_q[2];
  assign out_eol  = out_q[1];
  assign out_eof  = out_q[0];

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture (8x8 store) against
// a frame-level model of pixel storage and row-major replay.
module tb_frame_capture;

  localparam int MW = 8;
  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst, fval, lval, dval, arm, out_ready;
  logic [7:0]  pix_data;
  logic        busy, done, err_len, err_ovf;
  logic [15:0] frame_w, frame_h;
  logic        out_valid, out_sol, out_eol, out_eof;
  logic [7:0]  out_data;

  frame_capture #(.PIX_W(8), .MAX_W(MW), .MAX_H(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .fval      (fval),
    .lval      (lval),
    .dval      (dval),
    .pix_data  (pix_data),
    .arm       (arm),
    .busy      (busy),
    .done      (done),
    .frame_w   (frame_w),
    .frame_h   (frame_h),
    .err_len   (err_len),
    .err_ovf   (err_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int last_w;
    bit rnd; bit fclose; bit seq;
    int ew; int eh; bit elen; bit eovf;
  } vec_t;

  typedef struct {
    logic [7:0] data; bit known;
    bit sol; bit eol; bit eof;
  } beat_t;

  int tests = 0;
  int fails = 0;
  int lens[$];
  beat_t exp_q[$];
  logic [7:0] mmem [MW*MH];
  bit mknown [MW*MH];
  vec_t vt [8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    check("armed_busy", busy, 1);
  endtask

  task automatic drive_frame(input bit fclose, input bit seq);
    int idx = 0;
    @(negedge clk) fval = 1'b1;
    @(negedge clk);
    for (int r = 0; r < lens.size(); r++) begin
      lval = 1'b1;
      for (int c = 0; c < lens[r]; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          dval = 1'b0;
          pix_data = 8'($urandom);
          @(negedge clk);
        end
        dval = 1'b1;
        pix_data = seq ? 8'(idx) : 8'($urandom);
        if (c < MW && r < MH) begin
          mmem[r*MW+c] = pix_data;
          mknown[r*MW+c] = 1'b1;
        end
        idx++;
        @(negedge clk);
      end
      dval = 1'b0;
      if (fclose && r == lens.size() - 1) begin
        fval = 1'b0;
        @(negedge clk);
        lval = 1'b0;
        return;
      end
      lval = 1'b0;
      @(negedge clk);
    end
    fval = 1'b0;
  endtask

  task automatic build_exp(input int w, input int h);
    int sw = (w > MW) ? MW : w;
    int sh = (h > MH) ? MH : h;
    beat_t b;
    exp_q.delete();
    for (int y = 0; y < sh; y++)
      for (int x = 0; x < sw; x++) begin
        b.data  = mmem[y*MW+x];
        b.known = mknown[y*MW+x];
        b.sol   = (x == 0);
        b.eol   = (x == sw - 1);
        b.eof   = (x == sw - 1) && (y == sh - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic readout(input bit rnd);
    int got = 0;
    int eof_cyc = -10;
    bit seen = 0, held = 0, anyv = 0;
    logic [11:0] prev = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        if (exp_q.size() > 0) check("done_lat", cyc - eof_cyc, 1);
        check("valid_at_done", out_valid, 0);
        break;
      end
      if (held)
        check("hold",
              {out_valid, out_data, out_sol, out_eol, out_eof}, prev);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) anyv = 1;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) begin
          if (exp_q[got].known) check("data", out_data, exp_q[got].data);
          check("markers", {out_sol, out_eol, out_eof},
                {exp_q[got].sol, exp_q[got].eol, exp_q[got].eof});
        end else begin
          check("extra_beat", got, exp_q.size());
        end
        if (out_eof) eof_cyc = cyc;
        got++;
      end
      held = out_valid && !out_ready;
      prev = {out_valid, out_data, out_sol, out_eol, out_eof};
    end
    out_ready = 1'b1;
    check("beats", got, exp_q.size());
    check("done_seen", seen, 1);
    if (exp_q.size() == 0) check("no_valid", anyv, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle", busy, 0);
  endtask

  task automatic check_flags(input int ew, input int eh,
                             input bit el, input bit eo);
    check("frame_w", frame_w, ew);
    check("frame_h", frame_h, eh);
    check("err_len", err_len, el);
    check("err_ovf", err_ovf, eo);
  endtask

  task automatic set_lens(input vec_t v);
    lens.delete();
    for (int i = 0; i < v.h; i++)
      lens.push_back((i == v.h - 1 && v.last_w != 0) ? v.last_w : v.w);
  endtask

  task automatic run_vec(input vec_t v);
    do_arm();
    set_lens(v);
    drive_frame(v.fclose, v.seq);
    build_exp(v.ew, v.eh);
    readout(v.rnd);
    check_flags(v.ew, v.eh, v.elen, v.eovf);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    rst = 1'b1; fval = 1'b0; lval = 1'b0; dval = 1'b0;
    arm = 1'b0; out_ready = 1'b1; pix_data = '0;
    for (int i = 0; i < MW*MH; i++) mknown[i] = 1'b0;

    vt[0] = '{4, 3, 0, 0, 0, 1, 4, 3, 0, 0};
    vt[1] = '{4, 3, 3, 0, 0, 0, 4, 3, 1, 0};
    vt[2] = '{10, 2, 0, 0, 0, 0, 10, 2, 0, 1};
    vt[3] = '{5, 4, 0, 1, 0, 0, 5, 4, 0, 0};
    vt[4] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0};
    vt[5] = '{8, 8, 0, 1, 0, 0, 8, 8, 0, 0};
    vt[6] = '{3, 9, 0, 0, 0, 0, 3, 9, 0, 1};
    vt[7] = '{6, 2, 0, 1, 1, 0, 6, 2, 0, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check_flags(0, 0, 0, 0);

    foreach (vt[i]) run_vec(vt[i]);

    // arm while a frame is already running: it must be skipped
    @(negedge clk);
    fval = 1'b1; lval = 1'b1; dval = 1'b1; pix_data = 8'h5a;
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    repeat (3) @(negedge clk);
    lval = 1'b0; dval = 1'b0;
    @(negedge clk) fval = 1'b0;
    repeat (2) @(negedge clk);
    check("skip_busy", busy, 1);
    check("skip_done", done, 0);
    lens.delete();
    lens.push_back(2);
    lens.push_back(2);
    drive_frame(1'b0, 1'b0);
    build_exp(2, 2);
    readout(1'b1);
    check_flags(2, 2, 0, 0);

    // frame with fval but no lines
    do_arm();
    @(negedge clk) fval = 1'b1;
    repeat (4) @(negedge clk);
    fval = 1'b0;
    exp_q.delete();
    readout(1'b0);
    check_flags(0, 0, 0, 0);

    // reset in the middle of readout
    do_arm();
    set_lens(vt[0]);
    drive_frame(1'b0, 1'b1);
    build_exp(4, 3);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (got == 5) begin
        rst = 1'b1;
        break;
      end
      if (out_valid) begin
        check("rst_seq_data", out_data, exp_q[got].data);
        got++;
      end
    end
    check("rst_reach", got, 5);
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    run_vec('{3, 2, 0, 1, 0, 0, 3, 2, 0, 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
Name: frame_capture

Overview:
Synthesisable, parametrised successor to the simulation-only frame writer. It captures one complete frame from the fval/lval/dval video bus into on-chip RAM when armed, and measures the frame's width and height. It flags malformed frames, then replays the stored pixels in row-major order on a valid/ready stream with line and frame markers. It sits between the frame generator and downstream checkers or DMA.

Parameters:
PIX_W, 8, pixel data width in bits
MAX_W, 640, maximum stored pixels per line
MAX_H, 480, maximum stored lines per frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fval  in  1  frame valid
lval  in  1  line valid
dval  in  1  data valid
pix_data  in  PIX_W  input pixel
arm  in  1  one-cycle request to capture the next full frame
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of readout or of an empty frame
frame_w  out  16  measured width of the first line, saturating at 16'hFFFF
frame_h  out  16  measured line count, saturating at 16'hFFFF
err_len  out  1  sticky: some line length differed from the first line
err_ovf  out  1  sticky: pixels beyond MAX_W or lines beyond MAX_H were dropped
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  PIX_W  stream pixel
out_sol  out  1  first pixel of a line
out_eol  out  1  last pixel of a line
out_eof  out  1  last pixel of the frame

Behaviour:
- Reset:
  - Synchronous, active-high; clk and rst only.
  - On rst: state=IDLE; all outputs 0; counters 0.
  - RAM contents are don't-care.
  - rst mid-capture or mid-readout aborts immediately; no done pulse.
- Edge detection:
  - fval and lval are registered once (fval_q, lval_q).
  - rise = x & !x_q; fall = !x & x_q.
- States:
  - IDLE -> ARMED on arm. arm in any other state is ignored.
  - ARMED -> CAPTURE on fval rise. A frame already in progress when arm arrives is skipped entirely.
  - CAPTURE -> READOUT on fval fall if at least one line was seen, else -> IDLE with a done pulse and frame_w=frame_h=0.
  - READOUT -> IDLE in the cycle after the out_eof beat is accepted; done pulses in that cycle.
- Capture:
  - On entering CAPTURE, clear err_len and err_ovf.
  - lval rise: col=0.
  - Each cycle with lval & dval: write pix_data to address row*MAX_W+col when col<MAX_W and row<MAX_H; otherwise set err_ovf.
  - col increments every such cycle; the measurement counter saturates at 16'hFFFF.
  - lval fall: if row==0, frame_w=col; else if col!=frame_w, set err_len. Then row++ (saturating) and frame_h=row.
  - dval outside lval is ignored. lval outside fval is ignored.
  - fval fall while lval is high closes the line as if lval fell in the same cycle, then applies the fval-fall transition.
- Readout:
  - Stored area: SW=min(frame_w,MAX_W), SH=min(frame_h,MAX_H).
  - If SW==0, go directly to IDLE with done.
  - Pixels stream row-major. The RAM read is synchronous with 1-cycle latency, so out_valid first rises 2 cycles after entering READOUT.
  - The output register holds out_data and the markers stable while out_valid & !out_ready.
  - Beat accepted when out_valid & out_ready. Back-to-back beats at full rate when out_ready stays high; a one-entry skid or prefetch is required.
  - Markers: out_sol when x==0; out_eol when x==SW-1; out_eof when x==SW-1 and y==SH-1. A 1x1 frame asserts all three together.
  - Input bus activity during READOUT is ignored.
- Hold behaviour: frame_w, frame_h, err_len and err_ovf hold their values after done until the next CAPTURE entry.
- Width rules:
  - Counters are sized by $clog2(MAX_W+1) and $clog2(MAX_H+1), plus separate 16-bit saturating measurement counters.
  - The RAM address is $clog2(MAX_W*MAX_H) bits.

Decomposition:
- Package frame_pkg:
  - state encoding IDLE/ARMED/CAPTURE/READOUT as a 2-bit enum;
  - 16-bit measurement width constant;
  - address-width helper.
- Sub-module frame_ram: simple dual-port RAM, PIX_W x MAX_W*MAX_H, one write port, one synchronous read port, same clk.

Test Plan:
- MAX_W=8, MAX_H=8; arm, then a 4x3 frame with pixels 0..11 and out_ready=1 -> frame_w=4, frame_h=3, no errors, 12 beats 0..11, sol on beats 0/4/8, eol on 3/7/11, eof on 11, done 1 cycle later.
- Lines of 4, 4, 3 pixels -> err_len=1, frame_w=4, frame_h=3; readout of 12 beats, last line padded with stale RAM data. Only the flags are checked.
- 10-pixel lines into MAX_W=8 -> err_ovf=1, frame_w=10, readout of 8 beats per line.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly -> data sequence unchanged, with no drops or duplicates while held.
- arm asserted mid-frame -> that frame is skipped and the next frame is captured. Frame with fval but no lval -> done pulse, frame_w=frame_h=0, no out_valid.
- rst during READOUT at beat 5 -> the next cycle has busy=0 and out_valid=0, with no done. A new arm captures correctly.
